cpu_param: RTL

Parametrised multicycle 16-bit-instruction CPU core, the successor of the fixed-width lab CPU. It has an instruction register, a decoder, a controller FSM, an eight-entry register file, a shifter, an ALU and a status register. It generalises the datapath to `DATA_W` bits and adds illegal-instruction detection and busy-time load protection. It sits under the top-level board wrapper, which drives `in`/`load`/`s` from switches and shows `out`/flags on LEDs.

---
 rtl/cpu_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_param.sv
// Parametrised multicycle CPU core: 16-bit instructions, DATA_W-bit datapath, eight registers.
// Define CPU_PARAM_ALU_FLAGS_EN to make ADD/AND/MVN update N, V, Z as well as CMP.
module cpu_param #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    state_t state, state_next;

    logic [15:0]       ir;
    logic [DATA_W-1:0] a, b, c;
    logic [DATA_W-1:0] regs [8];

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_legal;
    logic [DATA_W-1:0] sximm8, bsh, ain, sum, diff, alu_res;
    logic       sub_v;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    assign sximm8 = DATA_W'($signed(ir[7:0]));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        bsh = b;
        case (sh)
            2'b01:   bsh = {b[DATA_W-2:0], 1'b0};
            2'b10:   bsh = {1'b0, b[DATA_W-1:1]};
            2'b11:   bsh = {b[DATA_W-1], b[DATA_W-1:1]};
            default: bsh = b;
        endcase
    end

    // MOV reg goes through the adder with a zero A operand.
    assign ain   = is_mov_reg ? '0 : a;
    assign sum   = ain + bsh;
    assign diff  = ain - bsh;
    assign sub_v = (ain[DATA_W-1] != bsh[DATA_W-1]) && (diff[DATA_W-1] != ain[DATA_W-1]);

    always_comb begin
        alu_res = sum;
        if (is_alu && op == 2'b10) alu_res = ain & bsh;
        if (is_alu && op == 2'b11) alu_res = ~bsh;
    end

`ifdef CPU_PARAM_ALU_FLAGS_EN
    logic add_v;
    assign add_v = (ain[DATA_W-1] == bsh[DATA_W-1]) && (sum[DATA_W-1] != ain[DATA_W-1]);
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:      if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)      state_next = S_WRITE_IMM;
                else if (is_mov_reg) state_next = S_GET_B;
                else if (is_alu)     state_next = S_GET_A;
                else                 state_next = S_WAIT;
            end
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_EXEC;
            S_EXEC:      state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            S_WRITE_IMM: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_WAIT;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            N       <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
            illegal <= 1'b0;
            // NOTE: the register file is architecturally visible and must read zero after reset.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (load) ir <= in;
                    if (s)    illegal <= 1'b0;
                end
                S_DECODE:    if (!is_legal) illegal <= 1'b1;
                S_GET_A:     a <= regs[rn];
                S_GET_B:     b <= regs[rm];
                S_EXEC: begin
                    if (is_cmp) begin
                        N <= diff[DATA_W-1];
                        Z <= (diff == '0);
                        V <= sub_v;
                    end else begin
                        c <= alu_res;
`ifdef CPU_PARAM_ALU_FLAGS_EN
                        if (is_alu) begin
                            N <= alu_res[DATA_W-1];
                            Z <= (alu_res == '0);
                            V <= (op == 2'b00) ? add_v : 1'b0;
                        end
`endif
                    end
                end
                S_WRITE_REG: regs[rd] <= c;
                S_WRITE_IMM: regs[rn] <= sximm8;
                default: ;
            endcase
        end
    end

    assign out = c;
    assign w   = (state == S_WAIT);

endmodule
